// File: rtl/if_id_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// IF/ID pipeline register, load-use hazard detection and wrong-path flushing.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] XADR_PC  = 32'h8000_0004,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] if_pc,
    input  logic [31:0] imem_rdata,
    input  logic [2:0]  id_pcsrc,
    input  logic [31:0] id_jr_target,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        idex_memrd,
    input  logic [4:0]  idex_rt,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic        id_ker,
    output logic        stall,
    output logic        idex_bubble
);

    localparam logic [2:0] PCSRC_J     = 3'b010;
    localparam logic [2:0] PCSRC_JR    = 3'b011;
    localparam logic [2:0] PCSRC_XADR  = 3'b100;
    localparam logic [2:0] PCSRC_ILLOP = 3'b101;

    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_plus4_reg, pc_plus4_next;
    logic [31:0] pc_plus4;
    logic [4:0]  src_field [2];
    logic [1:0]  src_match;
    logic        redirect_id;

    // Increment only the low 31 bits so the kernel bit never flips on carry.
    assign pc_plus4 = {pc_reg[31], pc_reg[30:0] + 31'd4};

    // Both register-source fields of the ID instruction are hazard candidates.
    assign src_field[0] = instr_reg[25:21];
    assign src_field[1] = instr_reg[20:16];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_src_match
            assign src_match[gi] = (idex_rt == src_field[gi]);
        end
    endgenerate

    // A load into $zero never creates a real dependency.
    assign stall = idex_memrd && (idex_rt != 5'd0) && (|src_match);

    // ID-stage redirects wait for the stall to drop so jr sees a forwarded rs.
    assign redirect_id = !stall &&
                         ((id_pcsrc == PCSRC_J)    || (id_pcsrc == PCSRC_JR) ||
                          (id_pcsrc == PCSRC_XADR) || (id_pcsrc == PCSRC_ILLOP));

    assign idex_bubble = stall || ex_br_taken;

    // Next-PC selection: EX branch beats stall, stall beats ID redirects.
    always_comb begin
        pc_next = pc_plus4;
        if (ex_br_taken) begin
            pc_next = ex_br_target;
        end else if (stall) begin
            pc_next = pc_reg;
        end else begin
            case (id_pcsrc)
                PCSRC_J:     pc_next = {pc_plus4_reg[31:28], instr_reg[25:0], 2'b00};
                PCSRC_JR:    pc_next = id_jr_target;
                PCSRC_XADR:  pc_next = XADR_PC;
                PCSRC_ILLOP: pc_next = ILLOP_PC;
                default:     pc_next = pc_plus4;
            endcase
        end
    end

    // IF/ID contents: squash on any redirect, freeze on stall, else capture fetch.
    always_comb begin
        instr_next    = imem_rdata;
        pc_plus4_next = pc_plus4;
        if (ex_br_taken || redirect_id) begin
            instr_next    = 32'h0000_0000;
            pc_plus4_next = pc_plus4;
        end else if (stall) begin
            instr_next    = instr_reg;
            pc_plus4_next = pc_plus4_reg;
        end
    end

    // State registers; reset discards any pending redirect or stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'h0000_0000;
            pc_plus4_reg <= RESET_PC;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_plus4_reg <= pc_plus4_next;
        end
    end

    assign if_pc       = pc_reg;
    assign id_instr    = instr_reg;
    assign id_pc_plus4 = pc_plus4_reg;
    assign id_opcode   = instr_reg[31:26];
    assign id_funct    = instr_reg[5:0];
    assign id_ker      = pc_plus4_reg[31];

endmodule
